// File: rtl/tone_synth.sv
// Multi-channel phase-accumulator tone synthesiser: per-channel waveform and volume, saturating mix, sign-split PWM.
// Sample path is two edges from tick to sample_out; no backpressure, ticks are consumed every cycle they are high.
module tone_synth #(
  parameter int CHANNELS = 4,
  parameter int PHASE_W  = 16,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_sel,
  input  logic [PHASE_W-1:0]  cfg_data,
  output logic signed [7:0]   sample_out,
  output logic                sample_valid,
  output logic                pwm_pos,
  output logic                pwm_neg
);

  localparam int SUM_W = 12;
  localparam logic signed [SUM_W-1:0] POS_LIM = 127;
  localparam logic signed [SUM_W-1:0] NEG_LIM = -127;

  logic [PHASE_W-1:0]  phase  [CHANNELS];
  logic [PHASE_W-1:0]  freq   [CHANNELS];
  logic [2:0]          mode   [CHANNELS];
  logic [7:0]          vol    [CHANNELS];
  logic signed [7:0]   scaled [CHANNELS];

  logic                tick_q;
  logic [6:0]          cnt;
  logic [6:0]          mag;
  logic                sign_q;
  logic signed [SUM_W-1:0] sum;
  logic signed [7:0]   mix;
  logic [7:0]          neg_out;

  // Quarter-wave sine table, sampled at bin centres so the mirror in quadrants 1/3 is exact.
  function automatic logic [6:0] sine_lut(input logic [5:0] i);
    logic [6:0] v;
    v = '0;
    case (i)
      6'd0:  v = 7'd2;   6'd1:  v = 7'd5;   6'd2:  v = 7'd8;   6'd3:  v = 7'd11;
      6'd4:  v = 7'd14;  6'd5:  v = 7'd17;  6'd6:  v = 7'd20;  6'd7:  v = 7'd23;
      6'd8:  v = 7'd26;  6'd9:  v = 7'd29;  6'd10: v = 7'd32;  6'd11: v = 7'd35;
      6'd12: v = 7'd38;  6'd13: v = 7'd41;  6'd14: v = 7'd44;  6'd15: v = 7'd47;
      6'd16: v = 7'd50;  6'd17: v = 7'd53;  6'd18: v = 7'd56;  6'd19: v = 7'd58;
      6'd20: v = 7'd61;  6'd21: v = 7'd64;  6'd22: v = 7'd67;  6'd23: v = 7'd69;
      6'd24: v = 7'd72;  6'd25: v = 7'd74;  6'd26: v = 7'd77;  6'd27: v = 7'd79;
      6'd28: v = 7'd82;  6'd29: v = 7'd84;  6'd30: v = 7'd86;  6'd31: v = 7'd89;
      6'd32: v = 7'd91;  6'd33: v = 7'd93;  6'd34: v = 7'd95;  6'd35: v = 7'd97;
      6'd36: v = 7'd99;  6'd37: v = 7'd101; 6'd38: v = 7'd103; 6'd39: v = 7'd105;
      6'd40: v = 7'd106; 6'd41: v = 7'd108; 6'd42: v = 7'd110; 6'd43: v = 7'd111;
      6'd44: v = 7'd113; 6'd45: v = 7'd114; 6'd46: v = 7'd115; 6'd47: v = 7'd117;
      6'd48: v = 7'd118; 6'd49: v = 7'd119; 6'd50: v = 7'd120; 6'd51: v = 7'd121;
      6'd52: v = 7'd122; 6'd53: v = 7'd123; 6'd54: v = 7'd124; 6'd55: v = 7'd124;
      6'd56: v = 7'd125; 6'd57: v = 7'd125; 6'd58: v = 7'd126; 6'd59: v = 7'd126;
      6'd60: v = 7'd127; 6'd61: v = 7'd127; 6'd62: v = 7'd127; 6'd63: v = 7'd127;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic signed [7:0] wave(input logic [2:0] m, input logic [7:0] p);
    logic [6:0]        l;
    logic signed [9:0] tri_v;
    logic signed [7:0] w;
    l = sine_lut(p[6] ? ~p[5:0] : p[5:0]);
    tri_v = p[7] ? (10'sd383 - $signed({1'b0, p, 1'b0})) : ($signed({1'b0, p, 1'b0}) - 10'sd128);
    w = '0;
    case (m)
      3'd1:    w = p[7] ? -8'sd127 : 8'sd127;
      3'd2:    w = $signed(p ^ 8'h80);
      3'd3:    w = tri_v[7:0];
      3'd4:    w = p[7] ? -$signed({1'b0, l}) : $signed({1'b0, l});
      default: w = '0;
    endcase
    return w;
  endfunction

  // Product >>> 8 always fits in 8 bits since volume tops out at 255.
  function automatic logic signed [7:0] scale(input logic signed [7:0] w, input logic [7:0] v);
    logic signed [16:0] prod;
    prod = 17'(w) * 17'($signed({1'b0, v}));
    return prod[15:8];
  endfunction

  always_comb begin
    sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum = sum + SUM_W'(scaled[c]);
    end
    if (sum > POS_LIM)      mix = 8'sd127;
    else if (sum < NEG_LIM) mix = -8'sd127;
    else                    mix = sum[7:0];
  end

  assign neg_out = -sample_out;
  assign pwm_pos = !sign_q && (cnt < mag);
  assign pwm_neg =  sign_q && (cnt < mag);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        phase[c]  <= '0;
        freq[c]   <= '0;
        mode[c]   <= '0;
        vol[c]    <= '0;
        scaled[c] <= '0;
      end
      tick_q       <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      cnt          <= '0;
      mag          <= '0;
      sign_q       <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sample_tick) scaled[c] <= scale(wave(mode[c], phase[c][PHASE_W-1 -: 8]), vol[c]);
        if (cfg_we && cfg_ch == CH_W'(c)) begin
          case (cfg_sel)
            2'd0:    freq[c] <= cfg_data;
            2'd1:    mode[c] <= cfg_data[2:0];
            2'd2:    vol[c]  <= cfg_data[7:0];
            default: ;
          endcase
        end
        // A phase load on the same edge as a tick replaces the increment.
        if (cfg_we && cfg_ch == CH_W'(c) && cfg_sel == 2'd3) phase[c] <= cfg_data;
        else if (sample_tick)                                phase[c] <= phase[c] + freq[c];
      end
      tick_q       <= sample_tick;
      sample_valid <= tick_q;
      if (tick_q) sample_out <= mix;
      cnt <= cnt + 7'd1;
      if (cnt == 7'd127) begin
        mag    <= sample_out[7] ? neg_out[6:0] : sample_out[6:0];
        sign_q <= sample_out[7];
      end
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: directed scenarios plus random traffic against a behavioural model, on a 4- and a 3-channel instance.
module tb_tone_synth;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sample_tick, cfg_we;
  logic [1:0]  cfg_ch, cfg_sel;
  logic [15:0] cfg_data;
  logic signed [7:0] so4, so3;
  logic v4, v3, pp4, pp3, pn4, pn3;

  tone_synth #(.CHANNELS(4), .PHASE_W(16)) u4 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .sample_out(so4), .sample_valid(v4),
    .pwm_pos(pp4), .pwm_neg(pn4));

  tone_synth #(.CHANNELS(3), .PHASE_W(16)) u3 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .sample_out(so3), .sample_valid(v3),
    .pwm_pos(pp3), .pwm_neg(pn3));

  int n_checks = 0;
  int n_pass   = 0;
  int lut [64];

  // Model state, index 0 = 4-channel instance, 1 = 3-channel instance.
  int m_phase [2][8], m_freq [2][8], m_mode [2][8], m_vol [2][8], m_scaled [2][8];
  int m_tq [2], m_out [2], m_valid [2], m_cnt [2], m_mag [2], m_neg [2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int wave_ref(input int m, input int p);
    int i;
    i = p % 64;
    case (m)
      1: return (p >= 128) ? -127 : 127;
      2: return p - 128;
      3: return (p >= 128) ? 383 - 2 * p : 2 * p - 128;
      4: case (p / 64)
           0: return lut[i];
           1: return lut[63 - i];
           2: return -lut[i];
           default: return -lut[63 - i];
         endcase
      default: return 0;
    endcase
  endfunction

  function automatic int scale_ref(input int w, input int v);
    return $rtoi($floor(real'(w * v) / 256.0));
  endfunction

  task automatic model_step(input int n, input int nch);
    int sum, np;
    if (reset) begin
      for (int c = 0; c < 8; c++) begin
        m_phase[n][c] = 0; m_freq[n][c] = 0; m_mode[n][c] = 0; m_vol[n][c] = 0; m_scaled[n][c] = 0;
      end
      m_tq[n] = 0; m_out[n] = 0; m_valid[n] = 0; m_cnt[n] = 0; m_mag[n] = 0; m_neg[n] = 0;
      return;
    end
    if (m_cnt[n] == 127) begin
      m_mag[n] = (m_out[n] < 0) ? -m_out[n] : m_out[n];
      m_neg[n] = (m_out[n] < 0) ? 1 : 0;
    end
    m_cnt[n] = (m_cnt[n] + 1) % 128;
    if (m_tq[n] != 0) begin
      sum = 0;
      for (int c = 0; c < nch; c++) sum += m_scaled[n][c];
      m_out[n] = (sum > 127) ? 127 : (sum < -127) ? -127 : sum;
    end
    m_valid[n] = m_tq[n];
    m_tq[n] = sample_tick ? 1 : 0;
    for (int c = 0; c < nch; c++) begin
      np = m_phase[n][c];
      if (sample_tick) begin
        m_scaled[n][c] = scale_ref(wave_ref(m_mode[n][c], m_phase[n][c] / 256), m_vol[n][c]);
        np = (m_phase[n][c] + m_freq[n][c]) % 65536;
      end
      if (cfg_we && int'(cfg_ch) == c) begin
        case (int'(cfg_sel))
          0: m_freq[n][c] = int'(cfg_data);
          1: m_mode[n][c] = int'(cfg_data) % 8;
          2: m_vol[n][c]  = int'(cfg_data) % 256;
          default: np = int'(cfg_data);
        endcase
      end
      m_phase[n][c] = np;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 3);
    #1;
    check("u4.sample_out", int'(so4), m_out[0]);
    check("u4.sample_valid", int'(v4), m_valid[0]);
    check("u4.pwm_pos", int'(pp4), (m_neg[0] == 0 && m_cnt[0] < m_mag[0]) ? 1 : 0);
    check("u4.pwm_neg", int'(pn4), (m_neg[0] != 0 && m_cnt[0] < m_mag[0]) ? 1 : 0);
    check("u3.sample_out", int'(so3), m_out[1]);
    check("u3.sample_valid", int'(v3), m_valid[1]);
    check("u3.pwm_pos", int'(pp3), (m_neg[1] == 0 && m_cnt[1] < m_mag[1]) ? 1 : 0);
    check("u3.pwm_neg", int'(pn3), (m_neg[1] != 0 && m_cnt[1] < m_mag[1]) ? 1 : 0);
  endtask

  task automatic cfg(input int ch, input int sel, input int data);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = 16'(data);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pwm_window(output int pos, output int neg);
    pos = 0; neg = 0;
    repeat (128) begin
      step();
      pos += int'(pp4);
      neg += int'(pn4);
    end
  endtask

  initial begin
    int pos, neg;
    for (int k = 0; k < 64; k++)
      lut[k] = $rtoi(127.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 128.0) + 0.5);
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 8; c++) begin
        m_phase[n][c] = 0; m_freq[n][c] = 0; m_mode[n][c] = 0; m_vol[n][c] = 0; m_scaled[n][c] = 0;
      end
      m_tq[n] = 0; m_out[n] = 0; m_valid[n] = 0; m_cnt[n] = 0; m_mag[n] = 0; m_neg[n] = 0;
    end
    reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    step(); step();
    reset = 1'b0;

    // Reset in the middle of activity.
    cfg(0, 1, 1); cfg(0, 2, 255); cfg(0, 0, 16'h1357);
    sample_tick = 1'b1;
    repeat (10) step();
    pulse_reset();
    check("rst.sample_out", int'(so4), 0);
    check("rst.sample_valid", int'(v4), 0);
    check("rst.pwm_pos", int'(pp4), 0);
    check("rst.pwm_neg", int'(pn4), 0);
    repeat (5) begin
      step();
      check("rst.hold_zero", int'(so4), 0);
    end
    sample_tick = 1'b0;

    // Square wave at half the phase range.
    pulse_reset();
    cfg(0, 1, 1); cfg(0, 2, 255); cfg(0, 0, 16'h8000);
    sample_tick = 1'b1;
    step(); step();
    check("sq.first", int'(so4), 126);
    check("sq.first_valid", int'(v4), 1);
    step();
    check("sq.second", int'(so4), -127);
    step();
    check("sq.third", int'(so4), 126);
    sample_tick = 1'b0;

    // Positive saturation.
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      cfg(c, 1, 1); cfg(c, 2, 255);
    end
    sample_tick = 1'b1;
    repeat (200) step();
    check("sat.sample_out", int'(so4), 127);
    pwm_window(pos, neg);
    check("sat.pos_duty", pos, 127);
    check("sat.neg_duty", neg, 0);
    sample_tick = 1'b0;

    // Most negative saw value.
    pulse_reset();
    cfg(0, 1, 2); cfg(0, 2, 255); cfg(0, 3, 0);
    sample_tick = 1'b1;
    repeat (200) step();
    check("saw.scaled", int'(u4.scaled[0]), -128);
    check("saw.sample_out", int'(so4), -127);
    pwm_window(pos, neg);
    check("saw.pos_duty", pos, 0);
    check("saw.neg_duty", neg, 127);
    sample_tick = 1'b0;

    // Sine peak and phase wrap.
    pulse_reset();
    cfg(0, 1, 4); cfg(0, 2, 255); cfg(0, 3, 16'h4000);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("sine.scaled", int'(u4.scaled[0]), 126);
    step();
    check("sine.sample_out", int'(so4), 126);
    cfg(0, 0, 16'h0100); cfg(0, 3, 16'hFF00);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("wrap.phase", int'(u4.phase[0]), 0);

    // Phase load colliding with a tick.
    cfg(0, 0, 16'h0010);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 2'd3; cfg_data = 16'h1234; sample_tick = 1'b1;
    step();
    cfg_we = 1'b0;
    check("coll.load_wins", int'(u4.phase[0]), 16'h1234);
    step();
    sample_tick = 1'b0;
    check("coll.next_tick", int'(u4.phase[0]), 16'h1244);

    // Channel index beyond the 3-channel instance is ignored there.
    cfg(3, 0, 16'hABCD);
    check("ign.u3_freq0", int'(u3.freq[0]), m_freq[1][0]);
    check("ign.u3_freq1", int'(u3.freq[1]), m_freq[1][1]);
    check("ign.u3_freq2", int'(u3.freq[2]), m_freq[1][2]);
    check("ign.u4_freq3", int'(u4.freq[3]), 16'hABCD);

    // Random traffic, including occasional mid-run resets.
    repeat (3000) begin
      reset       = ($urandom_range(0, 63) == 0);
      sample_tick = ($urandom_range(0, 3) != 0);
      cfg_we      = ($urandom_range(0, 3) == 0);
      cfg_ch      = 2'($urandom);
      cfg_sel     = 2'($urandom);
      cfg_data    = 16'($urandom);
      step();
    end
    check("rand.phase0", int'(u4.phase[0]), m_phase[0][0]);
    check("rand.phase1", int'(u4.phase[1]), m_phase[0][1]);
    check("rand.phase2", int'(u4.phase[2]), m_phase[0][2]);
    check("rand.phase3", int'(u4.phase[3]), m_phase[0][3]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tone_synth.md
# tone_synth

Multi-channel digital tone synthesiser. It generalises the single fixed sine source in the sound generator top to CHANNELS independent phase-accumulator oscillators, each with a selectable waveform and volume. The channels are mixed with saturation and driven out as a sign-split PWM pair (pwm_pos/pwm_neg) feeding the top-level output pins. A simple register-write port lets the top level or a future sequencer change frequency, waveform, volume and phase per channel.

## Interface
- CHANNELS, 4, number of oscillators (1..8); CH_W = max(1, clog2(CHANNELS))
- PHASE_W, 16, phase accumulator / frequency word width (>= 8)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- sample_tick  in  1  advance strobe; tie high for per-clock sampling
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_W  target channel; writes to cfg_ch >= CHANNELS ignored
- cfg_sel  in  2  0=freq, 1=mode (data[2:0]), 2=volume (data[7:0]), 3=phase load
- cfg_data  in  PHASE_W  write data
- sample_out  out  8  signed mixed sample, range -127..127
- sample_valid  out  1  one-cycle pulse when sample_out updates
- pwm_pos  out  1  PWM high for positive samples
- pwm_neg  out  1  PWM high for negative samples

## Operation
- Per channel regs: phase[PHASE_W], freq[PHASE_W], mode[3], vol[8]; all reset to 0.
- p = phase[PHASE_W-1 -: 8] (unsigned top byte). Wave w (signed 8b):
  - mode 0 off: 0; mode 1 square: p[7] ? -127 : +127; mode 2 saw: p - 128
  - mode 3 triangle: p[7] ? 383 - 2p : 2p - 128
  - mode 4 sine: q = p[7:6], i = p[5:0]; q0 lut[i], q1 lut[63-i], q2 -lut[i], q3 -lut[63-i]; lut[k] = round(127*sin(pi/2*(k+0.5)/64))
  - modes 5..7: treated as 0
- Scale: s = (w * vol) >>> 8 (signed × unsigned, arithmetic shift, floor); range -128..126.
- Mix: sum of all s in full width, saturated to [-127, +127].
- PWM: 7-bit free-running counter cnt 0..127. At cnt == 127 latch mag = |sample_out| (0..127) and sign. pwm_pos = !sign && cnt < mag; pwm_neg = sign && cnt < mag. Never both high.
- Config write (cfg_we): updates the selected field at the next edge. Freq/mode/vol take effect at the next tick.

## Timing
- Tick at edge t:
  - scaled[ch] is registered from the pre-increment phase.
  - phase <= phase + freq, mod 2^PHASE_W, wrapping silently.
- Edge t+1: sample_out <= saturated mix; sample_valid = 1 for exactly that cycle. Latency = 2 edges from tick sample to output.
- Back-to-back ticks produce back-to-back valid pulses.
- PWM reflects a sample from the next period boundary onward. Mid-period sample changes do not glitch the duty cycle.
- Simultaneous cfg phase-load and tick on the same channel: the load wins, phase <= cfg_data, and there is no increment that tick.
- Simultaneous freq write and tick: the increment uses the old freq.
- Reset (including mid-operation) clears, at that edge:
  - all channel regs and scaled pipeline
  - sample_out = 0, sample_valid = 0
  - cnt = 0, mag = 0, pwm_pos = pwm_neg = 0
- cfg_we and sample_tick are ignored while reset is high.

## Test plan
- Reset: drive activity, assert reset 1 cycle -> next cycle sample_out=0, sample_valid=0, pwm_pos=pwm_neg=0; with sample_tick held high, sample_out stays 0.
- Square: ch0 mode 1, vol 255, freq 0x8000, tick every cycle -> sample_out alternates +126, -127; first valid 2 edges after first tick is +126.
- Saturation: ch0..3 square, vol 255, freq 0 -> sample_out=+127; pwm_pos high 127 of every 128 cycles, pwm_neg never high.
- Negative/saw: ch0 mode 2, vol 255, phase load 0, freq 0 -> w=-128, s=-128, sample_out=-127; pwm_neg duty 127/128, pwm_pos 0.
- Sine and wrap: ch0 mode 4, vol 255, phase load 0x4000 -> w=lut[63]=127, s=126; freq 0x0100 from phase 0xFF00 -> phase wraps to 0x0000 after one tick.
- Collision: phase load 0x1234 and tick on the same cycle with freq 0x0010 -> phase=0x1234 after the edge, 0x1244 after the next tick; cfg_ch=CHANNELS write -> no register changes.
